enigma_encoder: RTL and testbench
=================================

# enigma_encoder

Three-rotor Enigma I machine that produces the ciphertext the drum bank later attacks. It is used as the on-chip crib/menu generator and as a self-check for the drum bank. Letters enter over a valid/ready stream and are stepped, plugged and scrambled exactly as the historical machine does, including the double-step anomaly. Each letter leaves with its message position, in the same (input, output, position) form the drum bank consumes.

## Interface
- No parameters. Rotor wirings I–V and reflector B are fixed historical tables. Ring setting is fixed at A.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; loads the key and restarts the message.
- rotor_config_0/1/2  in  3 each  rotor type: 0..4 = I..V. Index 0 is the fast (rightmost) rotor, index 2 the slow rotor.
- init_rotor_position_0/1/2  in  5 each  start positions 0..25, latched on start.
- rotor_turnover_0/1/2  in  5 each  notch letter per rotor; overrides the historical notch.
- pb_we  in  1  plugboard table write strobe.
- pb_addr  in  5  plugboard table index.
- pb_data  in  5  plugboard table value.
- in_valid  in  1  input letter valid.
- in_ready  out  1  input letter ready.
- in_letter  in  5  plaintext letter, 0..25.
- out_valid  out  1  output letter valid.
- out_ready  in  1  output letter ready.
- out_letter  out  5  ciphertext letter.
- out_position  out  8  message index of out_letter.
- out_error  out  1  set when the input letter was ≥26.
- rotor_position_0/1/2  out  5 each  current rotor positions.

## Operation
- Plugboard: 26×5 register table, reset to identity (entry i = i).
  - A write takes effect only when the FSM is in IDLE; otherwise it is ignored.
  - A write is one-directional, so software writes both halves of a swap.
- Key registers (types, turnovers, positions) are latched on start or reset. Reset loads the current input values.
- Position counter: 8 bits, cleared on start and reset, incremented after each valid letter, wraps 255→0.
- FSM states: IDLE, STEP, PB_IN, FWD0, FWD1, FWD2, REFL, BWD2, BWD1, BWD0, PB_OUT, HOLD.
  - in_ready = 1 only in IDLE.
  - in_valid & in_ready moves IDLE→STEP and captures in_letter.
  - States then advance one per cycle through PB_OUT to HOLD.
  - out_valid = 1 only in HOLD. HOLD→IDLE on out_ready.
- STEP uses pre-step positions p0, p1, p2. All three updates are simultaneous:
  - p0 always advances.
  - p1 advances if p0 == turnover_0 or p1 == turnover_1.
  - p2 advances if p1 == turnover_1.
  - Every advance wraps 25→0.
- Forward pass through a rotor at position p: t = W[(c+p) mod 26]; result = (t − p) mod 26.
- Backward pass uses the inverse wiring with the same offset rule.
- Arithmetic: all mod-26 results lie in 0..25. Use 6-bit intermediates; the encoder never produces 26..31.
- Letter ≥26:
  - The letter passes through with the same latency.
  - out_letter = in_letter and out_error = 1.
  - Rotors do not step and the position counter does not increment.
- rotor_config value 5..7 is treated as rotor I.
- start has priority over everything except reset, and acts in any state:
  - aborts any in-flight letter;
  - drops out_valid next cycle;
  - FSM goes to IDLE, the key is reloaded, and the counter is cleared;
  - the plugboard is unchanged.
- reset restores the plugboard to identity; start does not.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_letter = 0, out_position = 0, out_error = 0.
  - rotor_position_x = init_rotor_position_x.
- Latency: accept at edge T gives out_valid high from cycle T+11.
- Throughput: one letter per 12 cycles when out_ready is held high.
- rotor_position_x reflects the post-step value from the cycle after STEP.
- out_letter, out_position and out_error are stable while out_valid=1 and out_ready=0.
- start and in_valid in the same IDLE cycle: start wins and the letter is not accepted.
- pb_we in the same cycle as an IDLE acceptance: the write lands and the accepted letter uses the new entry.

## Test plan
- Basic encryption:
  - Setup: types (0,1,2) = (III, II, I), positions AAA, identity plugboard.
  - Stimulus: AAAAA.
  - Required: out BDZGO, positions 0..4, out_error = 0.
- Reciprocity:
  - Stimulus: start, then encrypt BDZGO with the same key.
  - Required: out AAAAA.
- Double-step:
  - Setup: (p2, p1, p0) = (A, D, U), turnovers V, E, Q.
  - Stimulus: three letters.
  - Required: positions step to ADV, then AEW, then BFX.
- Plugboard swap:
  - Setup: write 0→1 and 1→0, positions AAA.
  - Stimulus: in B.
  - Required: out A.
- Invalid letter:
  - Stimulus: in 27 sent mid-message.
  - Required: out 27 with out_error = 1; positions and counter unchanged.
  - Required: the next valid letter continues the sequence correctly.
- Backpressure, abort and wrap:
  - Stimulus: hold out_ready = 0 for 5 cycles.
  - Required: outputs stay stable while held.
  - Stimulus: pulse start while in FWD1.
  - Required: no output is emitted and the counter returns to 0.
  - Stimulus: 256 letters.
  - Required: out_position wraps to 0 on letter 256.

Source files
------------

// File: rtl/enigma_encoder.sv
// Three-rotor Enigma I (rotors I-V, reflector B, ring A) on a valid/ready letter stream.
// Latency: accept to out_valid is 11 edges; throughput 1 letter / 12 cycles; in_ready only in IDLE, HOLD waits on out_ready.
module enigma_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] rotor_config_0,
    input  logic [2:0] rotor_config_1,
    input  logic [2:0] rotor_config_2,
    input  logic [4:0] init_rotor_position_0,
    input  logic [4:0] init_rotor_position_1,
    input  logic [4:0] init_rotor_position_2,
    input  logic [4:0] rotor_turnover_0,
    input  logic [4:0] rotor_turnover_1,
    input  logic [4:0] rotor_turnover_2,
    input  logic       pb_we,
    input  logic [4:0] pb_addr,
    input  logic [4:0] pb_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic [7:0] out_position,
    output logic       out_error,
    output logic [4:0] rotor_position_0,
    output logic [4:0] rotor_position_1,
    output logic [4:0] rotor_position_2
);
    localparam logic [207:0] W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [207:0] W_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [207:0] W_IV  = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
    localparam logic [207:0] W_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
    localparam logic [207:0] REF_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [3:0] {
        IDLE, STEP, PB_IN, FWD0, FWD1, FWD2, REFL, BWD2, BWD1, BWD0, PB_OUT, HOLD
    } state_t;

    // Tables are ASCII strings, first letter in the top byte.
    function automatic logic [4:0] tbl_at(input logic [207:0] tbl, input logic [4:0] idx);
        logic [7:0] ch;
        int         k;
        k  = 25 - int'(idx);
        ch = tbl[8*k +: 8];
        return 5'(ch - 8'd65);
    endfunction

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    // Types 5..7 fall through to rotor I.
    function automatic logic [4:0] rotor_fwd(input logic [2:0] typ, input logic [4:0] c);
        logic [207:0] tbl;
        case (typ)
            3'd1:    tbl = W_II;
            3'd2:    tbl = W_III;
            3'd3:    tbl = W_IV;
            3'd4:    tbl = W_V;
            default: tbl = W_I;
        endcase
        return tbl_at(tbl, c);
    endfunction

    function automatic logic [4:0] rotor_inv(input logic [2:0] typ, input logic [4:0] c);
        logic [4:0] r;
        r = '0;
        for (int j = 0; j < 26; j++) begin
            if (rotor_fwd(typ, 5'(j)) == c) r = 5'(j);
        end
        return r;
    endfunction

    function automatic logic [4:0] fwd_pass(input logic [2:0] typ, input logic [4:0] p, input logic [4:0] c);
        return sub26(rotor_fwd(typ, add26(c, p)), p);
    endfunction

    function automatic logic [4:0] bwd_pass(input logic [2:0] typ, input logic [4:0] p, input logic [4:0] c);
        return sub26(rotor_inv(typ, add26(c, p)), p);
    endfunction

    state_t     state_q, state_d;
    logic [4:0] cur_q, cur_d;
    logic       err_q, err_d;
    logic [7:0] let_pos_q, let_pos_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] typ_q [3];
    logic [2:0] typ_d [3];
    logic [4:0] tov_q [3];
    logic [4:0] tov_d [3];
    logic [4:0] pos_q [3];
    logic [4:0] pos_d [3];
    logic [4:0] pb_q [26];
    logic [4:0] pb_d [26];
    logic       out_valid_q, out_valid_d;
    logic [4:0] out_letter_q, out_letter_d;
    logic [7:0] out_position_q, out_position_d;
    logic       out_error_q, out_error_d;

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        err_d          = err_q;
        let_pos_d      = let_pos_q;
        cnt_d          = cnt_q;
        typ_d          = typ_q;
        tov_d          = tov_q;
        pos_d          = pos_q;
        pb_d           = pb_q;
        out_valid_d    = out_valid_q;
        out_letter_d   = out_letter_q;
        out_position_d = out_position_q;
        out_error_d    = out_error_q;

        // Out-of-range address or data is dropped so the table stays a letter map.
        if (pb_we && state_q == IDLE && pb_addr < 5'd26 && pb_data < 5'd26)
            pb_d[pb_addr] = pb_data;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_d     = in_letter;
                    err_d     = (in_letter >= 5'd26);
                    let_pos_d = cnt_q;
                    state_d   = STEP;
                end
            end
            STEP: begin
                if (!err_q) begin
                    pos_d[0] = inc26(pos_q[0]);
                    if (pos_q[0] == tov_q[0] || pos_q[1] == tov_q[1]) pos_d[1] = inc26(pos_q[1]);
                    if (pos_q[1] == tov_q[1]) pos_d[2] = inc26(pos_q[2]);
                    cnt_d = cnt_q + 8'd1;
                end
                state_d = PB_IN;
            end
            PB_IN: begin
                if (!err_q) cur_d = pb_d[cur_q];
                state_d = FWD0;
            end
            FWD0: begin
                if (!err_q) cur_d = fwd_pass(typ_q[0], pos_q[0], cur_q);
                state_d = FWD1;
            end
            FWD1: begin
                if (!err_q) cur_d = fwd_pass(typ_q[1], pos_q[1], cur_q);
                state_d = FWD2;
            end
            FWD2: begin
                if (!err_q) cur_d = fwd_pass(typ_q[2], pos_q[2], cur_q);
                state_d = REFL;
            end
            REFL: begin
                if (!err_q) cur_d = tbl_at(REF_B, cur_q);
                state_d = BWD2;
            end
            BWD2: begin
                if (!err_q) cur_d = bwd_pass(typ_q[2], pos_q[2], cur_q);
                state_d = BWD1;
            end
            BWD1: begin
                if (!err_q) cur_d = bwd_pass(typ_q[1], pos_q[1], cur_q);
                state_d = BWD0;
            end
            BWD0: begin
                if (!err_q) cur_d = bwd_pass(typ_q[0], pos_q[0], cur_q);
                state_d = PB_OUT;
            end
            PB_OUT: begin
                out_letter_d   = err_q ? cur_q : pb_q[cur_q];
                out_position_d = let_pos_q;
                out_error_d    = err_q;
                out_valid_d    = 1'b1;
                state_d        = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Start aborts whatever is in flight and rekeys; the plugboard survives.
        if (start) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            typ_d[0] = rotor_config_0;        typ_d[1] = rotor_config_1;        typ_d[2] = rotor_config_2;
            tov_d[0] = rotor_turnover_0;      tov_d[1] = rotor_turnover_1;      tov_d[2] = rotor_turnover_2;
            pos_d[0] = init_rotor_position_0; pos_d[1] = init_rotor_position_1; pos_d[2] = init_rotor_position_2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            err_q          <= 1'b0;
            let_pos_q      <= '0;
            cnt_q          <= '0;
            typ_q[0] <= rotor_config_0;        typ_q[1] <= rotor_config_1;        typ_q[2] <= rotor_config_2;
            tov_q[0] <= rotor_turnover_0;      tov_q[1] <= rotor_turnover_1;      tov_q[2] <= rotor_turnover_2;
            pos_q[0] <= init_rotor_position_0; pos_q[1] <= init_rotor_position_1; pos_q[2] <= init_rotor_position_2;
            for (int i = 0; i < 26; i++) pb_q[i] <= 5'(i);
            out_valid_q    <= 1'b0;
            out_letter_q   <= '0;
            out_position_q <= '0;
            out_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            err_q          <= err_d;
            let_pos_q      <= let_pos_d;
            cnt_q          <= cnt_d;
            typ_q          <= typ_d;
            tov_q          <= tov_d;
            pos_q          <= pos_d;
            pb_q           <= pb_d;
            out_valid_q    <= out_valid_d;
            out_letter_q   <= out_letter_d;
            out_position_q <= out_position_d;
            out_error_q    <= out_error_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign out_valid        = out_valid_q;
    assign out_letter       = out_letter_q;
    assign out_position     = out_position_q;
    assign out_error        = out_error_q;
    assign rotor_position_0 = pos_q[0];
    assign rotor_position_1 = pos_q[1];
    assign rotor_position_2 = pos_q[2];
endmodule

// File: tb/tb_enigma_encoder.sv
// Directed bench for enigma_encoder: known Enigma I vectors, double-step, plugboard,
// invalid letters, backpressure, abort and position wrap.
module tb_enigma_encoder;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [2:0] rotor_config_0, rotor_config_1, rotor_config_2;
    logic [4:0] init_rotor_position_0, init_rotor_position_1, init_rotor_position_2;
    logic [4:0] rotor_turnover_0, rotor_turnover_1, rotor_turnover_2;
    logic       pb_we;
    logic [4:0] pb_addr, pb_data;
    logic       in_valid, in_ready;
    logic [4:0] in_letter;
    logic       out_valid, out_ready;
    logic [4:0] out_letter;
    logic [7:0] out_position;
    logic       out_error;
    logic [4:0] rotor_position_0, rotor_position_1, rotor_position_2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    enigma_encoder dut (
        .clk(clk), .reset(reset), .start(start),
        .rotor_config_0(rotor_config_0), .rotor_config_1(rotor_config_1), .rotor_config_2(rotor_config_2),
        .init_rotor_position_0(init_rotor_position_0), .init_rotor_position_1(init_rotor_position_1),
        .init_rotor_position_2(init_rotor_position_2),
        .rotor_turnover_0(rotor_turnover_0), .rotor_turnover_1(rotor_turnover_1), .rotor_turnover_2(rotor_turnover_2),
        .pb_we(pb_we), .pb_addr(pb_addr), .pb_data(pb_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
        .out_valid(out_valid), .out_ready(out_ready), .out_letter(out_letter),
        .out_position(out_position), .out_error(out_error),
        .rotor_position_0(rotor_position_0), .rotor_position_1(rotor_position_1),
        .rotor_position_2(rotor_position_2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int t0, input int t1, input int t2,
                            input int p0, input int p1, input int p2);
        rotor_config_0 = 3'(t0); rotor_config_1 = 3'(t1); rotor_config_2 = 3'(t2);
        init_rotor_position_0 = 5'(p0); init_rotor_position_1 = 5'(p1); init_rotor_position_2 = 5'(p2);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pb_write(input int a, input int d);
        pb_we = 1'b1; pb_addr = 5'(a); pb_data = 5'(d);
        tick();
        pb_we = 1'b0;
    endtask

    // lat = edges from the accepting edge to the edge that takes the output.
    task automatic send(input int l, output int ol, output int op, output int oe, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin tick(); n++; end
        in_valid = 1'b1; in_letter = 5'(l);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin tick(); lat++; end
        if (!out_valid) check_eq("out_valid_timeout", 0, 1);
        ol = out_letter; op = out_position; oe = out_error;
        lat = lat + 1;
        tick();
    endtask

    task automatic run_msg(input string tag, input string pt, input string ct, input int base);
        int ol, op, oe, lat;
        for (int i = 0; i < pt.len(); i++) begin
            send(int'(pt[i]) - 65, ol, op, oe, lat);
            check_eq({tag, "_letter"}, ol, int'(ct[i]) - 65);
            check_eq({tag, "_pos"}, op, base + i);
            check_eq({tag, "_err"}, oe, 0);
        end
    endtask

    initial begin
        int ol, op, oe, lat, seen;
        reset = 1'b1; start = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_data = '0;
        in_valid = 1'b0; in_letter = '0; out_ready = 1'b1;
        rotor_config_0 = 3'd2; rotor_config_1 = 3'd1; rotor_config_2 = 3'd0;
        init_rotor_position_0 = 5'd3; init_rotor_position_1 = 5'd7; init_rotor_position_2 = 5'd11;
        rotor_turnover_0 = 5'd21; rotor_turnover_1 = 5'd4; rotor_turnover_2 = 5'd16;
        tick(); tick();
        reset = 1'b0;

        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_letter", out_letter, 0);
        check_eq("rst_out_position", out_position, 0);
        check_eq("rst_out_error", out_error, 0);
        check_eq("rst_rotor_pos0", rotor_position_0, 3);
        check_eq("rst_rotor_pos1", rotor_position_1, 7);
        check_eq("rst_rotor_pos2", rotor_position_2, 11);

        // Rotors III, II, I at AAA: AAAAA -> BDZGO, first letter also checks latency.
        load_key(2, 1, 0, 0, 0, 0);
        send(0, ol, op, oe, lat);
        check_eq("latency", lat, 11);
        check_eq("basic_first_letter", ol, 1);
        run_msg("basic", "AAAA", "DZGO", 1);

        load_key(2, 1, 0, 0, 0, 0);
        run_msg("recip", "BDZGO", "AAAAA", 0);

        load_key(2, 1, 5, 0, 0, 0);
        run_msg("cfg5_as_I", "AAAAA", "BDZGO", 0);

        // Double step from ADU.
        load_key(2, 1, 0, 20, 3, 0);
        check_eq("dstep_p0_init", rotor_position_0, 20);
        send(0, ol, op, oe, lat);
        check_eq("dstep1_p0", rotor_position_0, 21);
        check_eq("dstep1_p1", rotor_position_1, 3);
        check_eq("dstep1_p2", rotor_position_2, 0);
        send(0, ol, op, oe, lat);
        check_eq("dstep2_p0", rotor_position_0, 22);
        check_eq("dstep2_p1", rotor_position_1, 4);
        check_eq("dstep2_p2", rotor_position_2, 0);
        send(0, ol, op, oe, lat);
        check_eq("dstep3_p0", rotor_position_0, 23);
        check_eq("dstep3_p1", rotor_position_1, 5);
        check_eq("dstep3_p2", rotor_position_2, 1);

        // Invalid letter mid-message passes through without stepping.
        load_key(2, 1, 0, 0, 0, 0);
        run_msg("pre_inv", "AA", "BD", 0);
        send(27, ol, op, oe, lat);
        check_eq("inv_letter", ol, 27);
        check_eq("inv_err", oe, 1);
        check_eq("inv_pos", op, 2);
        check_eq("inv_rotor_p0", rotor_position_0, 2);
        check_eq("inv_rotor_p1", rotor_position_1, 0);
        run_msg("post_inv", "AAA", "ZGO", 2);

        // Plugboard A<->B, then reset must restore identity.
        pb_write(0, 1);
        pb_write(1, 0);
        load_key(2, 1, 0, 0, 0, 0);
        run_msg("pb_swap", "B", "A", 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_msg("pb_after_reset", "A", "B", 0);

        // start together with in_valid in IDLE: the letter is dropped.
        in_valid = 1'b1; in_letter = 5'd0;
        load_key(2, 1, 0, 0, 0, 0);
        in_valid = 1'b0;
        check_eq("start_vs_valid_ready", in_ready, 1);
        check_eq("start_vs_valid_rotor", rotor_position_0, 0);

        // Backpressure for five cycles.
        out_ready = 1'b0;
        in_valid = 1'b1; in_letter = 5'd0;
        tick();
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 30) begin tick(); seen++; end
        check_eq("bp_first_letter", out_letter, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_letter", out_letter, 1);
            check_eq("bp_hold_pos", out_position, 0);
            check_eq("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", out_valid, 0);

        // Abort in FWD1: three edges after the accepting edge.
        in_valid = 1'b1; in_letter = 5'd0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        load_key(2, 1, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check_eq("abort_no_output", seen, 0);
        run_msg("after_abort", "AA", "BD", 0);

        // Position counter wraps 255 -> 0.
        load_key(2, 1, 0, 0, 0, 0);
        for (int i = 0; i < 257; i++) begin
            send(0, ol, op, oe, lat);
            if (i == 255) check_eq("wrap_pos_255", op, 255);
            if (i == 256) check_eq("wrap_pos_0", op, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
